// File: rtl/latch_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : latch_bank_arbiter
// Description : Round-robin arbiter between two write requesters that share
//               one bank of DEPTH clocked D latches. Each write is sequenced
//               as SETUP (drive D) -> PULSE (latch enable high) -> HOLD (D
//               held for settle time) -> ACK (completion pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module latch_bank_arbiter #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] lat_d,
  output logic [DEPTH-1:0] lat_en,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  // Counter loads are "remaining cycles minus one"; the counter never wraps.
  localparam logic [3:0]       c_pulse_load  = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0]       c_settle_load = 4'(SETTLE_CYCLES - 1);
  localparam logic [DEPTH-1:0] c_en_one      = DEPTH'(1);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_gnt;
  logic          r_last_grant;

  logic          w_pick;
  logic [AW-1:0] w_addr;
  logic [WIDTH-1:0] w_data;

  // Round-robin pick: a lone request wins outright, a tie goes to the
  // requester that was not granted last time.
  always_comb begin
    w_pick = 1'b0;
    if (req == 2'b11) begin
      w_pick = ~r_last_grant;
    end else begin
      w_pick = req[1];
    end
    w_addr = w_pick ? addr1 : addr0;
    w_data = w_pick ? data1 : data0;
  end

  // Write sequencer; all outputs are registered so that lat_en and lat_d
  // never glitch and lat_d only moves on the edge that enters SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= '0;
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      ack          <= 2'b00;
      lat_d        <= '0;
      lat_en       <= '0;
      busy         <= 1'b0;
    end else begin
      ack <= 2'b00;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'd0;
          if (req != 2'b00) begin
            r_gnt        <= w_pick;
            r_last_grant <= w_pick;
            r_addr       <= w_addr;
            lat_d        <= w_data;
            busy         <= 1'b1;
            r_state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          lat_en  <= c_en_one << r_addr;
          r_cnt   <= c_pulse_load;
          r_state <= S_PULSE;
        end
        S_PULSE: begin
          if (r_cnt == 4'd0) begin
            lat_en <= '0;
            if (SETTLE_CYCLES == 0) begin
              ack     <= 2'b01 << r_gnt;
              r_state <= S_ACK;
            end else begin
              r_cnt   <= c_settle_load;
              r_state <= S_HOLD;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == 4'd0) begin
            ack     <= 2'b01 << r_gnt;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACK: begin
          r_cnt   <= 4'd0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= 4'd0;
          lat_en  <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_latch_bank_arbiter
// Description : Scoreboard bench for latch_bank_arbiter. A transaction-level
//               model predicts each grant from the request stream and pushes
//               the expected write/ack; a negedge monitor compares outputs.
//               A second instance covers the PULSE_CYCLES=1, SETTLE_CYCLES=0
//               build with a directed write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_bank_arbiter;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int P  = 2;
  localparam int S  = 1;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  data0, data1;
  logic [1:0]    ack;
  logic [W-1:0]  lat_d;
  logic [D-1:0]  lat_en;
  logic          busy;

  logic [1:0]    f_req;
  logic [AW-1:0] f_addr0, f_addr1;
  logic [W-1:0]  f_data0, f_data1;
  logic [1:0]    f_ack;
  logic [W-1:0]  f_lat_d;
  logic [D-1:0]  f_lat_en;
  logic          f_busy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  latch_bank_arbiter #(.WIDTH(W), .DEPTH(D), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1), .ack(ack), .lat_d(lat_d), .lat_en(lat_en), .busy(busy)
  );

  latch_bank_arbiter #(.WIDTH(W), .DEPTH(D), .PULSE_CYCLES(1), .SETTLE_CYCLES(0)) dut_fast (
    .clk(clk), .rst_n(rst_n), .req(f_req), .addr0(f_addr0), .addr1(f_addr1),
    .data0(f_data0), .data1(f_data1), .ack(f_ack), .lat_d(f_lat_d), .lat_en(f_lat_en),
    .busy(f_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [D-1:0] onehot(input logic [AW-1:0] a);
    logic [D-1:0] one;
    one = 1;
    return one << a;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    int           who;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    int           ack_cyc;
  } txn_t;

  txn_t          q[$];
  int            cyc = 0;
  int            next_free = 0;
  int            busy_end = 0;
  int            pulse_lo = 1;
  int            pulse_hi = 0;
  int            last = 1;
  logic [AW-1:0] cur_addr = '0;
  logic [W-1:0]  exp_lat_d = '0;

  // A grant is possible whenever the previous write has fully retired; its
  // whole timeline follows from the grant edge by simple arithmetic.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      next_free = 0;
      busy_end  = 0;
      pulse_lo  = 1;
      pulse_hi  = 0;
      last      = 1;
      exp_lat_d = '0;
    end else begin
      cyc++;
      if (cyc >= next_free && req != 2'b00) begin
        txn_t t;
        if (req == 2'b11) t.who = (last == 1) ? 0 : 1;
        else              t.who = req[1] ? 1 : 0;
        t.addr    = (t.who == 1) ? addr1 : addr0;
        t.data    = (t.who == 1) ? data1 : data0;
        t.ack_cyc = cyc + 1 + P + S;
        q.push_back(t);
        last      = t.who;
        cur_addr  = t.addr;
        exp_lat_d = t.data;
        pulse_lo  = cyc + 1;
        pulse_hi  = cyc + P;
        busy_end  = cyc + 2 + P + S;
        next_free = cyc + 3 + P + S;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [W-1:0] prev_lat_d = '0;

  always @(negedge clk) begin
    logic [D-1:0] exp_en;
    exp_en = (cyc >= pulse_lo && cyc <= pulse_hi) ? onehot(cur_addr) : '0;
    chk("lat_en", lat_en, exp_en);
    chk("lat_d", lat_d, exp_lat_d);
    chk("busy", busy, (cyc < busy_end) ? 1 : 0);
    chk("lat_en_onehot0", $onehot0(lat_en), 1);
    chk("ack_not_both", (ack == 2'b11) ? 1 : 0, 0);
    chk("fast_lat_en_onehot0", $onehot0(f_lat_en), 1);
    chk("fast_ack_not_both", (f_ack == 2'b11) ? 1 : 0, 0);
    if (lat_en != '0) chk("lat_d_stable", lat_d, prev_lat_d);
    if (q.size() > 0 && q[0].ack_cyc == cyc) begin
      chk("ack", ack, 2'b01 << q[0].who);
      void'(q.pop_front());
    end else if (ack != 2'b00) begin
      chk("spurious_ack", ack, 0);
    end
    prev_lat_d = lat_d;
  end

  // ---------------- fast build: P=1, S=0 ----------------
  initial begin
    f_req = 2'b01; f_addr0 = 2'd1; f_addr1 = 2'd0; f_data0 = 8'h5A; f_data1 = 8'h00;
    @(posedge rst_n);
    @(posedge clk); #1;
    chk("fast_grant_busy", f_busy, 1);
    chk("fast_setup_lat_d", f_lat_d, 8'h5A);
    chk("fast_setup_lat_en", f_lat_en, 0);
    f_req = 2'b00;
    @(posedge clk); #1;
    chk("fast_pulse_lat_en", f_lat_en, 4'b0010);
    chk("fast_pulse_ack", f_ack, 0);
    @(posedge clk); #1;
    chk("fast_ack", f_ack, 2'b01);
    chk("fast_ack_lat_en", f_lat_en, 0);
    @(posedge clk); #1;
    chk("fast_ack_done", f_ack, 0);
    chk("fast_idle_busy", f_busy, 0);
    chk("fast_lat_d_kept", f_lat_d, 8'h5A);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req = 2'b01; addr0 = 2'd2; data0 = 8'hA5; addr1 = 2'd0; data1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_lat_en", lat_en, 0);
    chk("reset_lat_d", lat_d, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ack", ack, 0);
    rst_n = 1'b1;
    // single write granted on the first edge after release
    @(posedge clk); #1;
    req = 2'b00;
    repeat (10) @(posedge clk);

    // reset in the second PULSE cycle aborts the write
    #1 req = 2'b01; addr0 = 2'd3; data0 = 8'h77;
    @(posedge clk); #1 req = 2'b00;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_reset_lat_en", lat_en, 4'b1000);
    #1 rst_n = 1'b0;
    #1;
    chk("async_lat_en", lat_en, 0);
    chk("async_lat_d", lat_d, 0);
    chk("async_busy", busy, 0);
    chk("async_ack", ack, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);

    // tie after reset: requester 0 first, then alternating
    #1 req = 2'b11; addr0 = 2'd0; addr1 = 2'd1; data0 = 8'h11; data1 = 8'h22;
    repeat (14) @(posedge clk);
    #1 req = 2'b00;
    repeat (10) @(posedge clk);

    // input churn while the write is in PULSE
    #1 req = 2'b01; addr0 = 2'd1; data0 = 8'h3C;
    @(posedge clk);
    @(posedge clk); #1 addr0 = 2'd3; data0 = 8'hFF; req = 2'b00;
    repeat (10) @(posedge clk);

    // randomized traffic with addr/data churning every cycle
    for (int i = 0; i < 400; i++) begin
      #1;
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      addr0 = 2'($urandom); addr1 = 2'($urandom);
      data0 = 8'($urandom); data1 = 8'($urandom);
      @(posedge clk);
    end
    #1 req = 2'b00;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1 chk("pending_txn", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
